serial_adder: RTL
=================

# serial_adder

Multi-cycle, parametrised adder/subtractor built around a DIGIT-bit full-adder slice and a carry register. It processes WIDTH-bit operands DIGIT bits per clock, LSB first. A valid/ready handshake sits on both input and output. It is the sequential, width-generic successor to the team's single-bit full adder, for datapaths where area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 1.
- DIGIT, 1, bits processed per clock; WIDTH % DIGIT must be 0; N = WIDTH/DIGIT cycles per operation.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept; equals (state == IDLE).
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- Ci  input  1  carry-in (add) / borrow-in (subtract).
- Sub  input  1  0: S = A + B + Ci; 1: S = A − B − Ci.
- out_valid  output  1  result available; equals (state == DONE).
- out_ready  input  1  consumer accepts result.
- S  output  WIDTH  result, registered.
- Co  output  1  add: carry-out; subtract: 1 = no borrow, 0 = borrow.
- Ovf  output  1  two's-complement signed overflow (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on in_valid & in_ready. The same edge latches:
  - opA = A
  - opB = B ^ {WIDTH{Sub}}
  - carry = Ci ^ Sub
  - cnt = 0
- RUN, each cycle:
  - {c, d} = opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - opA and opB shift right by DIGIT.
  - The result shift register shifts right by DIGIT, with d inserted at the top.
  - carry = c; cnt increments.
- RUN → DONE on the cycle where cnt == N−1. That edge loads S from the final shift value and sets Co = final carry.
- Ovf = carry into MSB XOR carry out of MSB, computed inside the last digit.
- DONE → IDLE on out_valid & out_ready. There is no DONE → RUN bypass.
- Inputs A, B, Ci and Sub are ignored outside the accept edge, so they may change freely during RUN and DONE.
- in_valid is ignored while in_ready = 0. No request is queued and none is lost silently; the producer must hold in_valid.
- S, Co and Ovf hold their value from completion until the next completion or reset.
- Arithmetic is modulo 2^WIDTH; the carry is the only width extension.
- WIDTH = DIGIT (N = 1) is legal: the block spends exactly one cycle in RUN.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE, cnt = 0
  - S = 0, Co = 0, Ovf = 0
  - out_valid = 0
  - in_ready = 1 from the cycle after the reset edge
- Reset mid-RUN or in DONE aborts the operation: no out_valid, no partial result is exposed, and the outputs clear as above.
- Latency: if accept happens at edge k, out_valid goes high after edge k+N.
- Minimum issue interval: N+2 cycles (accept, N RUN cycles, output handshake cycle).
- Output stalls: out_valid, S, Co and Ovf stay stable for as long as out_ready = 0. There is no timeout.
- in_valid and out_ready can never both be effective in the same cycle, because the IDLE and DONE states are disjoint.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - The MSB carry-in is tracked in the last digit.
  - Ovf reports signed overflow for both add and subtract.
- SERIAL_ADDER_OVF_EN undefined:
  - No overflow logic is built.
  - Ovf is tied to 0, including after reset.
  - The port is still present, so instantiations do not change.

## Test plan
- WIDTH=8, DIGIT=1: A=8'h0F, B=8'h01, Ci=0, Sub=0 → S=8'h10, Co=0, Ovf=0. out_valid rises exactly 8 edges after the accept edge.
- A=8'hFF, B=8'h01, Ci=1, Sub=0 → S=8'h01, Co=1, Ovf=0.
- A=8'h7F, B=8'h01, Ci=0, Sub=0 → S=8'h80, Co=0. Ovf=1 with SERIAL_ADDER_OVF_EN, Ovf=0 without.
- A=8'h05, B=8'h07, Ci=0, Sub=1 → S=8'hFE, Co=0 (borrow), Ovf=0.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands → S, Co, out_valid stable and in_ready=0. After the out_ready handshake → IDLE, then the new operands are accepted.
- Assert rst_n=0 for one edge in the 3rd RUN cycle → out_valid never rises, S=0, in_ready=1. Repeat test 1 with DIGIT=4 → out_valid after 2 edges, same result.
- Exhaustive sweep at WIDTH=4, DIGIT in {1,2,4}: all A, B, Ci, Sub → compared against a reference model.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to build the signed-overflow flag; otherwise Ovf is tied low.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 1) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               co_q, co_d;

  logic [DIGIT:0]       digit_sum;
  logic [WIDTH+DIGIT-1:0] shift_ext;
  logic                 last_digit;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  logic msb_carry_in;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    shift_d = shift_q;
    s_d     = s_q;
    co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    digit_sum  = {1'b0, op_a_q[DIGIT-1:0]} + {1'b0, op_b_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry_q};
    // Appending the new digit above the register and dropping the low DIGIT bits stays legal when N = 1.
    shift_ext  = {digit_sum[DIGIT-1:0], shift_q};
    last_digit = (cnt_q == CNT_W'(N - 1));
`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit, so no second adder is needed.
    msb_carry_in = op_a_q[DIGIT-1] ^ op_b_q[DIGIT-1] ^ digit_sum[DIGIT-1];
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = A;
          op_b_d  = B ^ {WIDTH{Sub}};
          carry_d = Ci ^ Sub;
          cnt_d   = '0;
          shift_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        op_a_d  = op_a_q >> DIGIT;
        op_b_d  = op_b_q >> DIGIT;
        shift_d = shift_ext[WIDTH+DIGIT-1:DIGIT];
        carry_d = digit_sum[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_digit) begin
          s_d     = shift_ext[WIDTH+DIGIT-1:DIGIT];
          co_d    = digit_sum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = msb_carry_in ^ digit_sum[DIGIT];
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      shift_q <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      shift_q <= shift_d;
      s_q     <= s_d;
      co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign Co        = co_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign Ovf       = ovf_q;
`else
  assign Ovf       = 1'b0;
`endif

endmodule
